piso_tx: RTL
============

// Module: piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: takes a WIDTH-bit word from a register
//  (writer side) and sends it out bit-serially, one bit per accepted cycle.
//  Sits between the ALU result register and any serial link/receiver.
//  Optional even-parity bit is appended after the data bits.
// PARAMETERS
//  WIDTH      8  data word width in bits (>= 2)
//  LSB_FIRST  1  1: bit 0 sent first; 0: bit WIDTH-1 sent first
//  PARITY_EN  1  1: append one even-parity bit after the data; 0: data only
// PORTS
//  clk         in   1      single clock, all state updates on posedge
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  load_valid  in   1      data_in is valid and offered for transmission
//  data_in     in   WIDTH  word to send; sampled only on load accept
//  load_ready  out  1      block can accept a word (state IDLE)
//  tx_ready    in   1      downstream accepts tx_bit this cycle
//  tx_valid    out  1      tx_bit is valid (state SHIFT or PARITY)
//  tx_bit      out  1      current serial bit
//  tx_last     out  1      tx_bit is the final bit of the frame
//  done        out  1      one-cycle pulse after the final bit is accepted
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, shift reg=0, bit count=0,
//    tx_valid=0, tx_bit=0, tx_last=0, done=0, load_ready=1 once released.
//  - States: IDLE, SHIFT, PARITY. load_ready = (state==IDLE).
//  - IDLE: on posedge with load_valid=1 -> capture data_in into shift reg,
//    capture parity = ^data_in, count=0, go SHIFT. load_valid=0 -> stay.
//  - SHIFT: tx_valid=1; tx_bit = shreg[0] (LSB_FIRST) else shreg[WIDTH-1];
//    combinational from registers, so first bit appears the cycle after accept.
//    On posedge with tx_ready=1: shift by one (toward the output end, fill 0),
//    count++. When count==WIDTH-1 and tx_ready=1: go PARITY if PARITY_EN,
//    else go IDLE and set done=1 for the next cycle.
//    tx_ready=0: hold shift reg, count, tx_bit stable (no bit lost/repeated).
//  - PARITY: tx_valid=1, tx_bit = captured parity (even: total ones incl.
//    parity bit is even). tx_ready=1 -> go IDLE, done=1 next cycle.
//  - tx_last=1 on the final bit only: PARITY state, or count==WIDTH-1 in
//    SHIFT when PARITY_EN=0.
//  - done: registered, high exactly one cycle, coincides with first IDLE
//    cycle; load may be accepted in that same cycle (1-cycle frame gap min).
//  - load_valid while not IDLE: ignored, not queued; data_in don't-care.
//  - Frame length in accepted beats: WIDTH + PARITY_EN. Count width
//    $clog2(WIDTH) bits; never wraps past WIDTH-1.
//  - Reset asserted mid-frame: frame aborted immediately, tx_valid drops
//    asynchronously, no done pulse; after release block is IDLE.
// TESTING
//  1 WIDTH=8,LSB_FIRST=1,PARITY_EN=1, load 0xA5, tx_ready=1 -> tx_bit
//    1,0,1,0,0,1,0,1 then parity 0 (tx_last=1), done pulse next cycle.
//  2 Same with 0x07 -> bits 1,1,1,0,0,0,0,0 then parity 1; LSB_FIRST=0,
//    0x80 -> 1,0,0,0,0,0,0,0 then parity 1.
//  3 0xA5 with tx_ready low for 3 cycles at bit 3 -> tx_bit/tx_last held,
//    sequence identical to scenario 1, total frame = 9 + 3 cycles.
//  4 load_valid held high, words 0x3C then 0xC3 -> second accepted in done
//    cycle; load_ready=0 throughout frame; mid-frame data_in change ignored.
//  5 reset=0 during bit 4 of 0xFF -> tx_valid=0 at once, no done; after
//    release load_ready=1 and a new load 0x01 transmits cleanly.
//  6 PARITY_EN=0, 0x5A -> 8 beats, tx_last on beat 8, done follows.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with an optional trailing even-parity bit.
// Latency: first bit valid the cycle after load accept; done pulses one cycle after the final beat.
// Backpressure: tx_ready low freezes the shift register, count and tx_bit; load_ready is low while a frame is active.
//
// Ports:
//   clk        - single clock, all state updates on posedge
//   reset      - asynchronous active-low reset (0 = reset)
//   load_valid - data_in offered for transmission
//   data_in    - WIDTH-bit word, sampled only when load is accepted
//   load_ready - high in IDLE; a word is accepted on load_valid & load_ready
//   tx_ready   - downstream accepts tx_bit this cycle
//   tx_valid   - tx_bit is valid (SHIFT or PARITY)
//   tx_bit     - current serial bit
//   tx_last    - tx_bit is the final bit of the frame
//   done       - one-cycle pulse in the first IDLE cycle after the final beat
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             par_bit;
  logic             out_end;
  logic             last_data_beat;

  // Bit sitting at the output end of the shift register.
  assign out_end        = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];
  assign last_data_beat = (count == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      count   <= '0;
      par_bit <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg   <= data_in;
            par_bit <= ^data_in;
            count   <= '0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (tx_ready) begin
            // Move the next bit toward the output end, zero-filling behind it.
            if (LSB_FIRST) begin
              shreg <= shreg >> 1;
            end else begin
              shreg <= shreg << 1;
            end
            if (last_data_beat) begin
              // Count parks at WIDTH-1 rather than wrapping.
              if (PARITY_EN) begin
                state <= PARITY;
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        PARITY: begin
          if (tx_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Serial outputs are decoded straight from registered state, so they
  // change only on clock edges or on asynchronous reset.
  always_comb begin
    load_ready = (state == IDLE);
    tx_valid   = (state == SHIFT) || (state == PARITY);
    tx_bit     = 1'b0;
    tx_last    = 1'b0;
    case (state)
      SHIFT: begin
        tx_bit  = out_end;
        tx_last = !PARITY_EN && last_data_beat;
      end
      PARITY: begin
        tx_bit  = par_bit;
        tx_last = 1'b1;
      end
      default: begin
        tx_bit  = 1'b0;
        tx_last = 1'b0;
      end
    endcase
  end

endmodule
